ddr4_axi_upsizer_w_pack: RTL

Write-data packer for the DDR4 AXI upsizer. It takes narrow slave W beats, one full-width slave beat per beat, and places each beat into its lane of a wide master word. It emits the wide word at a lane boundary or on the last beat of a burst. It sits directly downstream of the upsizer's word-position comparison logic and consumes per-burst command data from the AW path (start lane, wrap mask). It drives the wide W channel toward the memory controller.

---
 rtl/ddr4_axi_upsizer_w_pack.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ddr4_axi_upsizer_w_pack.sv
// ddr4_axi_upsizer_w_pack
// Write-data packer for the DDR4 AXI upsizer. Places narrow slave W beats into
// their lanes of a wide master word and emits the word at a lane boundary or
// on the last beat of a burst.
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   cmd_*                 per-burst command from the AW path (start lane, wrap mask)
//   S_AXI_W*              narrow slave write-data channel
//   M_AXI_W*              wide master write-data channel toward the memory controller
module ddr4_axi_upsizer_w_pack #(
   parameter string       C_FAMILY       = "virtex6",
   parameter int unsigned C_S_DATA_WIDTH = 32,
   parameter int unsigned C_M_DATA_WIDTH = 128,
   localparam int unsigned C_RATIO       = C_M_DATA_WIDTH / C_S_DATA_WIDTH,
   localparam int unsigned C_RATIO_LOG   = $clog2(C_RATIO),
   localparam int unsigned S_STRB_W      = C_S_DATA_WIDTH / 8,
   localparam int unsigned M_STRB_W      = C_M_DATA_WIDTH / 8
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      cmd_valid,
   input  logic [C_RATIO_LOG-1:0]    cmd_first_word,
   input  logic [C_RATIO_LOG-1:0]    cmd_wrap_mask,
   output logic                      cmd_ready,
   input  logic [C_S_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [S_STRB_W-1:0]       S_AXI_WSTRB,
   input  logic                      S_AXI_WLAST,
   input  logic                      S_AXI_WVALID,
   output logic                      S_AXI_WREADY,
   output logic [C_M_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [M_STRB_W-1:0]       M_AXI_WSTRB,
   output logic                      M_AXI_WLAST,
   output logic                      M_AXI_WVALID,
   input  logic                      M_AXI_WREADY
);

   // Elaboration-time configuration guard
   if (C_FAMILY == "" || C_RATIO < 2 || C_RATIO > 16 ||
       C_RATIO * C_S_DATA_WIDTH != C_M_DATA_WIDTH ||
       (C_RATIO & (C_RATIO - 1)) != 0) begin : g_bad_cfg
      $error("ddr4_axi_upsizer_w_pack: unsupported configuration");
   end

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                    state, state_next;
   logic [C_RATIO_LOG-1:0]    w, mask, w_next;
   logic [C_M_DATA_WIDTH-1:0] acc_data, merged_data, m_wdata;
   logic [M_STRB_W-1:0]       acc_strb, merged_strb, m_wstrb;
   logic                      cmd_ready_q, m_wvalid, m_wlast;
   logic                      cmd_acc, beat_acc, emit;

   assign cmd_ready    = cmd_ready_q;
   assign M_AXI_WDATA  = m_wdata;
   assign M_AXI_WSTRB  = m_wstrb;
   assign M_AXI_WLAST  = m_wlast;
   assign M_AXI_WVALID = m_wvalid;

   // Accept beats only while the output register is free or draining
   assign S_AXI_WREADY = (state == ACTIVE) & (~m_wvalid | M_AXI_WREADY);
   assign beat_acc     = S_AXI_WVALID & S_AXI_WREADY;
   assign cmd_acc      = cmd_valid & cmd_ready_q;

   // Masked lane increment: bits outside the wrap mask stay fixed
   assign w_next = (w & ~mask) | ((w + C_RATIO_LOG'(1)) & mask);
   assign emit   = S_AXI_WLAST | ((&mask) & (w == C_RATIO_LOG'(C_RATIO - 1)));

   // Accumulator with the current beat dropped into lane w
   always_comb begin
      merged_data = acc_data;
      merged_strb = acc_strb;
      merged_data[32'(w) * C_S_DATA_WIDTH +: C_S_DATA_WIDTH] = S_AXI_WDATA;
      merged_strb[32'(w) * S_STRB_W +: S_STRB_W]             = S_AXI_WSTRB;
   end

   // State register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (cmd_acc)                  state_next = ACTIVE;
         ACTIVE:  if (beat_acc && S_AXI_WLAST)  state_next = IDLE;
         default:                               state_next = IDLE;
      endcase
   end

   // Datapath: lane pointer, accumulator, output register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         cmd_ready_q <= 1'b0;
         w           <= '0;
         mask        <= '0;
         acc_data    <= '0;
         acc_strb    <= '0;
         m_wdata     <= '0;
         m_wstrb     <= '0;
         m_wlast     <= 1'b0;
         m_wvalid    <= 1'b0;
      end else begin
         cmd_ready_q <= (state_next == IDLE);

         if (cmd_acc) begin
            w    <= cmd_first_word;
            mask <= cmd_wrap_mask;
         end else if (beat_acc) begin
            w <= w_next;
         end

         // Strobes clear on emit so unwritten lanes of the next word read 0
         if (beat_acc) begin
            acc_data <= merged_data;
            acc_strb <= emit ? '0 : merged_strb;
         end

         if (beat_acc && emit) begin
            m_wdata  <= merged_data;
            m_wstrb  <= merged_strb;
            m_wlast  <= S_AXI_WLAST;
            m_wvalid <= 1'b1;
         end else if (M_AXI_WREADY) begin
            m_wvalid <= 1'b0;
         end
      end
   end

endmodule
